bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter sharing the CPU's single tri-state data bus among up to `NREQ` requesters (instruction controller, I/O loader, debug port, ...). Sits between the requesters and the tri-state driver decode. Issues one-hot grants with a mandatory one-cycle turnaround between owners so no two drivers ever overlap on the bus. Bounds bus occupancy with a hold limit; an optional lock overrides the limit.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `MAX_HOLD`, 8, max consecutive grant cycles before preemption when others wait (1..255)
- `SEL_W`, 2, width of `gnt_id`; must equal clog2(`NREQ`)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req` in `NREQ`: bit i = requester i wants the bus; level, held for the whole transfer
- `lock` in `NREQ`: bit i = requester i must not be preempted (see Configuration)
- `gnt` out `NREQ`: one-hot grant, registered; all-zero = bus undriven
- `gnt_id` out `SEL_W`: binary index of current or last grantee
- `busy` out 1: high whenever `gnt` is nonzero
- `turn` out 1: high during the turnaround cycle

## Operation
- States: IDLE, GRANT, TURN.
- Reset values: state IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `turn`=0, priority pointer `ptr`=0, hold counter `cnt`=0.
- Arbitration (IDLE or TURN exit): winner = first i with `req[i]`=1 scanning `ptr`, `ptr`+1, ... mod `NREQ`. On entering GRANT: `gnt`=1<<winner, `gnt_id`=winner, `ptr`=(winner+1) mod `NREQ`, `cnt`=1.
- IDLE: any `req` → GRANT; else stay.
- GRANT, owner o:
  - `req[o]`=0 → TURN.
  - else `cnt`==`MAX_HOLD` and any other `req` set (and not locked) → TURN, preempted.
  - else stay; `cnt` increments, saturating at `MAX_HOLD`.
- A sole requester is never preempted, so `cnt` saturates and the grant continues indefinitely.
- TURN: `gnt`=0, `turn`=1 for exactly one cycle. Then: any `req` → GRANT via arbitration; else IDLE.
- A preempted requester that keeps `req` high re-queues. It wins again only after every other pending requester has been served once.
- `gnt_id` holds its value through TURN and IDLE.
- `gnt` is never asserted for a requester whose `req` was low at the granting edge.

## Timing
- Latency: `req` rising before edge N, bus idle → `gnt` high after edge N (1 cycle).
- Release: `req[o]` low before edge N → `gnt`=0 after N. Next grant earliest after N+1.
- Max ownership under contention: `MAX_HOLD` cycles. Rotation period with all requesting = `MAX_HOLD`+1.
- Simultaneous `req[o]` drop and hold expiry: normal release, same TURN behaviour.
- `rst` mid-grant: all outputs clear immediately (asynchronous, no clock edge needed). After deassertion, arbitration restarts from `ptr`=0.
- Any `req` bit changing during TURN is sampled only at the TURN exit edge.

## Configuration
- `ARB_LOCK_EN` defined: in GRANT, `lock[o]`=1 suppresses preemption regardless of `cnt`. Release then occurs only on `req[o]` drop. Normal preemption resumes the cycle after `lock[o]` falls, if `cnt`==`MAX_HOLD`.
- `ARB_LOCK_EN` undefined: `lock` port present but ignored; preemption is purely `MAX_HOLD` based.

## Test plan
- Reset, `NREQ`=4, `MAX_HOLD`=8: assert `rst` with random `req` → `gnt`=0000, `gnt_id`=0, `busy`=0, `turn`=0 with no clock edge.
- `req`=0100 from edge 1 to edge 5: `gnt`=0100 and `gnt_id`=2 after edges 1–4. `gnt`=0000 and `turn`=1 after edge 5. IDLE after edge 6.
- `req`=1111 held: grants 0,1,2,3,0 in order, each `gnt` lasting 8 cycles, separated by exactly one all-zero `turn` cycle (period 9).
- `req`=1000 alone for 20 cycles → `gnt`=1000 continuously with no turnaround. Add `req[1]` at cycle 20 → TURN after edge 21, `gnt`=0010 after edge 22.
- `req`=0011, `lock`=0001, `ARB_LOCK_EN` defined → `gnt`=0001 for 15 cycles until `lock[0]` falls, then TURN and `gnt`=0010. Macro undefined → preempted after cycle 8.
- `rst` pulsed mid-grant of requester 3 with `req`=1001 → `gnt` clears asynchronously. First grant after release goes to requester 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grants, one idle turnaround cycle between
// owners and a hold limit. Define ARB_LOCK_EN to let lock[owner] suppress preemption.
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8,
  parameter int SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_id,
  output logic             busy,
  output logic             turn
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [7:0]       cnt;

  logic [SEL_W:0]   pick_res;
  logic             found;
  logic [SEL_W-1:0] winner;
  logic             owner_req;
  logic             others;
  logic             lock_hold;
  logic             hold_done;
  logic             release_now;

  // Round-robin search: first requester at or after p, wrapping modulo NREQ.
  function automatic logic [SEL_W:0] pick(input logic [NREQ-1:0] r,
                                          input logic [SEL_W-1:0] p);
    logic [SEL_W:0] res;
    logic [SEL_W:0] pos;
    res = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, p} + (SEL_W+1)'(k);
      if (pos >= (SEL_W+1)'(NREQ))
        pos = pos - (SEL_W+1)'(NREQ);
      if (!res[SEL_W] && r[pos[SEL_W-1:0]])
        res = {1'b1, pos[SEL_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    logic [SEL_W:0] s;
    s = {1'b0, i} + (SEL_W+1)'(1);
    return (s >= (SEL_W+1)'(NREQ)) ? '0 : s[SEL_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c >= HOLD_MAX) ? HOLD_MAX : c + 8'd1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  assign pick_res  = pick(req, ptr);
  assign found     = pick_res[SEL_W];
  assign winner    = pick_res[SEL_W-1:0];
  assign owner_req = |(req & gnt);
  assign others    = |(req & ~gnt);
  assign hold_done = (cnt == HOLD_MAX);

`ifdef ARB_LOCK_EN
  assign lock_hold = |(lock & gnt);
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign lock_hold   = 1'b0;
`endif

  // A sole requester is never preempted; hold expiry only matters when others wait.
  assign release_now = !owner_req || (hold_done && others && !lock_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      turn   <= 1'b0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, TURN: begin
          turn <= 1'b0;
          if (found) begin
            state  <= GRANT;
            gnt    <= onehot(winner);
            gnt_id <= winner;
            busy   <= 1'b1;
            ptr    <= wrap_inc(winner);
            cnt    <= 8'd1;
          end else begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= TURN;
            gnt   <= '0;
            busy  <= 1'b0;
            turn  <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          turn  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter with a queue-based scoreboard fed by a
// transaction-level arbitration model.
module tb_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
  localparam int SEL_W    = 2;

`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  lock = '0;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] gnt_id;
  logic             busy;
  logic             turn;

  bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lock   (lock),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .turn   (turn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] id;
    logic             busy;
    logic             turn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference: owner (-1 = nobody), last grantee, next-priority index, cycles held,
  // and whether the bus is in its mandatory gap cycle.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_gap   = 1'b0;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_gap   = 1'b0;
  endfunction

  function automatic void model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    int              w;
    int              idx;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] own;
    bit              others;
    bit              locked;
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        rot = r >> idx;
        if (w < 0 && rot[0]) w = idx;
      end
      m_gap = 1'b0;
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_ptr   = (w + 1) % NREQ;
        m_held  = 1;
      end
    end else begin
      own    = NREQ'(1) << m_owner;
      others = (r & ~own) != '0;
      locked = LOCK_EN && ((l & own) != '0);
      if ((r & own) == '0 || (m_held >= MAX_HOLD && others && !locked)) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (m_held < MAX_HOLD) begin
        m_held = m_held + 1;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    e.id   = SEL_W'(m_last);
    e.busy = (m_owner >= 0);
    e.turn = m_gap;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d: got gnt/id/busy/turn=%b want %b", name, cyc, act, want);
    end
  endtask

  // Monitor: outputs settle after each edge; compare against the oldest prediction.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("cycle", {gnt, gnt_id, busy, turn}, e);
    end
  end

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    @(negedge clk);
    req  = r;
    lock = l;
    model_edge(r, l);
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r_during);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = r_during;
    #1;
    check("rst_async", {gnt, gnt_id, busy, turn}, 8'h00);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    req  = '0;
    lock = '0;
    rst  = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    #1;
    check("rst_initial", {gnt, gnt_id, busy, turn}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Single requester: grant, release, turnaround, idle.
    repeat (5) step(4'b0100, 4'b0000);
    repeat (3) step(4'b0000, 4'b0000);

    // Full contention rotation.
    do_reset(4'($urandom));
    repeat (45) step(4'b1111, 4'b0000);

    // Sole requester saturates, then a second one forces preemption.
    do_reset(4'($urandom));
    repeat (20) step(4'b1000, 4'b0000);
    repeat (4) step(4'b1010, 4'b0000);
    repeat (2) step(4'b0000, 4'b0000);

    // Lock on requester 0 while requester 1 waits.
    do_reset(4'($urandom));
    repeat (15) step(4'b0011, 4'b0001);
    repeat (12) step(4'b0011, 4'b0000);

    // Reset while requester 3 owns the bus; restart from index 0.
    do_reset(4'($urandom));
    repeat (2) step(4'b1000, 4'b0000);
    repeat (3) step(4'b1001, 4'b0000);
    do_reset(4'b1001);
    repeat (4) step(4'b1001, 4'b0000);

    // Random traffic with sticky request/lock levels and occasional resets.
    r = '0;
    l = '0;
    for (int n = 0; n < 800; n++) begin
      r = r ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      l = l ^ (4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(199) == 0) begin
        do_reset(4'($urandom));
        r = '0;
        l = '0;
      end
      step(r, l);
    end

    @(posedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
